// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply scheduler: element width,
// scheduler states and the packed-matrix element offset.
package matmul_pkg;

    localparam int ELEM_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENG_RST = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Bit offset of element (r,c) in a row-major packed n x n matrix.
    function automatic int off(input int r, input int c, input int n);
        return ELEM_W * (r * n + c);
    endfunction

endpackage

// File: rtl/matmul_operand_sel.sv
// Combinational extraction of row i of A and column j of B from the latched
// packed matrices, laid out as engine vector slots.
module matmul_operand_sel
    import matmul_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [ELEM_W*N*N-1:0]    mat_a,
    input  logic [ELEM_W*N*N-1:0]    mat_b,
    input  logic [$clog2(N)-1:0]     i,
    input  logic [$clog2(N)-1:0]     j,
    output logic [ELEM_W*N-1:0]      row,
    output logic [ELEM_W*N-1:0]      column
);

    localparam int OW = $clog2(ELEM_W * N * N);

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign row[ELEM_W*k +: ELEM_W]    = mat_a[OW'(off(int'(i), k, N)) +: ELEM_W];
        assign column[ELEM_W*k +: ELEM_W] = mat_b[OW'(off(k, int'(j), N)) +: ELEM_W];
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Walks one inner-product engine over every (i,j) of C = A*B in row-major
// order, writing each result out and guarding every element with a watchdog.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int N          = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ELEM_W*N*N-1:0]      mat_a,
    input  logic [ELEM_W*N*N-1:0]      mat_b,
    output logic [ELEM_W*N-1:0]        ip_row,
    output logic [ELEM_W*N-1:0]        ip_column,
    output logic                       ip_start,
    output logic                       ip_rst,
    input  logic [ELEM_W-1:0]          ip_result,
    input  logic                       ip_done,
    output logic                       res_we,
    output logic [$clog2(N*N)-1:0]     res_addr,
    output logic [ELEM_W-1:0]          res_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 state_dbg
);

    localparam int IW = $clog2(N);
    localparam int AW = $clog2(N * N);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam int CW = $clog2(RST_CYCLES) + 1;

    state_t                  state, state_nxt;
    logic [ELEM_W*N*N-1:0]   a_q, b_q;
    logic [IW-1:0]           i_q, j_q;
    logic [CW-1:0]           rst_cnt;
    logic [WW-1:0]           wd;
    logic [ELEM_W-1:0]       res_q;
    logic                    last;
    logic                    wd_expired;

    assign last       = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
    assign wd_expired = (wd == WW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ENG_RST;
            ENG_RST: if (rst_cnt == CW'(RST_CYCLES - 1)) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ip_done) state_nxt = WRITE;
                     else if (wd_expired) state_nxt = IDLE;
            WRITE:   state_nxt = last ? DONE : ENG_RST;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything outside IDLE; start wins in IDLE
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            rst_cnt  <= '0;
            wd       <= '0;
            res_q    <= '0;
            ip_rst   <= 1'b0;
            ip_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            ip_rst   <= (state_nxt == ISSUE) || (state_nxt == WAIT) || (state_nxt == WRITE);
            ip_start <= (state_nxt == ISSUE) || (state_nxt == WAIT);
            done     <= (state_nxt == DONE);
            rst_cnt  <= (state == ENG_RST) ? rst_cnt + CW'(1) : '0;
            case (state)
                IDLE: if (start) begin
                    a_q <= mat_a;
                    b_q <= mat_b;
                    i_q <= '0;
                    j_q <= '0;
                    err <= 1'b0;
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + WW'(1);
                    if (ip_done) res_q <= ip_result;
                    else if (wd_expired && !abort) err <= 1'b1;
                end
                WRITE: if (!abort) begin
                    if (j_q == IW'(N - 1)) begin
                        j_q <= '0;
                        i_q <= last ? '0 : i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The write strobe is gated by abort in the same cycle, so it stays combinational.
    assign res_we    = (state == WRITE) && !abort;
    assign res_addr  = AW'(i_q) * AW'(N) + AW'(j_q);
    assign res_data  = res_q;
    assign state_dbg = state;

    matmul_operand_sel #(.N(N)) u_operand_sel (
        .mat_a  (a_q),
        .mat_b  (b_q),
        .i      (i_q),
        .j      (j_q),
        .row    (ip_row),
        .column (ip_column)
    );

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler: a latency-programmable engine model,
// a write scoreboard and a linear sequence of jobs covering the main scenarios.
module tb_matmul_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [511:0] mat_a = '0;
    logic [511:0] mat_b = '0;
    logic [127:0] ip_row, ip_column;
    logic         ip_start, ip_rst;
    logic         ip_done = 1'b0;
    logic [31:0]  ip_result = '0;
    logic         res_we;
    logic [3:0]   res_addr;
    logic [31:0]  res_data;
    logic         busy, done, err;
    logic [2:0]   state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int eng_lat = 5;
    int e_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int low_run = 0;
    logic start_prev = 1'b0;
    int a_m[4][4];
    int b_m[4][4];
    logic [35:0] wr_q[$];
    logic [35:0] exp_q[$];

    matmul_scheduler #(.N(N), .RST_CYCLES(2), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .ip_row    (ip_row),
        .ip_column (ip_column),
        .ip_start  (ip_start),
        .ip_rst    (ip_rst),
        .ip_result (ip_result),
        .ip_done   (ip_done),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    function automatic logic [31:0] dot(input logic [127:0] r, input logic [127:0] c);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + r[32*k +: 32] * c[32*k +: 32];
        return s;
    endfunction

    // engine model: done appears on the eng_lat-th WAIT cycle, held until ip_rst low
    always @(posedge clk) begin
        if (!ip_rst) begin
            e_cnt     <= 0;
            ip_done   <= 1'b0;
            ip_result <= '0;
        end else if (ip_start && !ip_done) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt + 1 == eng_lat) begin
                ip_done   <= 1'b1;
                ip_result <= dot(ip_row, ip_column);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: collect writes and done pulses, check ip_rst low time before each issue
    always @(negedge clk) begin
        if (res_we) wr_q.push_back({res_addr, res_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ip_start && !start_prev) chk("rst_low_before_issue", 64'(low_run), 64'd2);
        start_prev = ip_start;
        if (busy && !ip_rst) low_run++;
        else low_run = 0;
    end

    // driver tasks
    task automatic load_mats(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (kind == 0) begin
                    a_m[r][c] = (r == c) ? 1 : 0;
                    b_m[r][c] = 16 * r + c;
                end else begin
                    a_m[r][c] = r + 1;
                    b_m[r][c] = c + 1;
                end
                mat_a[32*(r*N+c) +: 32] = 32'(a_m[r][c]);
                mat_b[32*(r*N+c) +: 32] = 32'(b_m[r][c]);
            end
    endtask

    task automatic kick(input int lat);
        eng_lat = lat;
        wr_q.delete();
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic go_to(input int p);
        while (cyc < t0 + p) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    // scoreboard: first n row-major elements of A*B from the bench's own arrays
    task automatic check_writes(input string tag, input int n);
        exp_q.delete();
        for (int e = 0; e < n; e++) begin
            int s;
            s = 0;
            for (int k = 0; k < N; k++) s = s + a_m[e/N][k] * b_m[k][e%N];
            exp_q.push_back({4'(e), 32'(s)});
        end
        chk({tag, "_count"}, 64'(wr_q.size()), 64'(n));
        for (int k = 0; k < n; k++)
            if (k < wr_q.size()) chk(tag, 64'(wr_q[k]), 64'(exp_q[k]));
    endtask

    initial begin
        load_mats(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ip_rst", 64'(ip_rst), 64'd0);
        chk("rst_ip_start", 64'(ip_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res_we", 64'(res_we), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_res_addr", 64'(res_addr), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // identity job, plus a start pulse mid-job that must be ignored
        kick(5);
        go_to(20);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("id_idle", 400);
        chk("id_busy_fall", 64'(cyc - t0), 64'd145);
        chk("id_done_cycle", 64'(done_cyc - t0), 64'd144);
        chk("id_done_count", 64'(done_cnt), 64'd1);
        chk("id_err", 64'(err), 64'd0);
        check_writes("id_wr", 16);

        // general product, engine latency 3
        load_mats(1);
        kick(3);
        wait_idle("gen_idle", 400);
        chk("gen_busy_fall", 64'(cyc - t0), 64'd113);
        chk("gen_done_count", 64'(done_cnt), 64'd1);
        chk("gen_addr15", 64'(wr_q.size() == 16 ? wr_q[15] : 36'h0), {28'd0, 4'd15, 32'd64});
        check_writes("gen_wr", 16);

        // timeout: engine never finishes
        kick(1000);
        wait_idle("to_idle", 100);
        chk("to_fall", 64'(cyc - t0), 64'd11);
        chk("to_err", 64'(err), 64'd1);
        chk("to_writes", 64'(wr_q.size()), 64'd0);
        chk("to_done", 64'(done_cnt), 64'd0);

        // next start clears err and completes normally
        kick(3);
        chk("to_err_clear", 64'(err), 64'd0);
        wait_idle("rec_idle", 400);
        chk("rec_done", 64'(done_cnt), 64'd1);
        chk("rec_err", 64'(err), 64'd0);
        check_writes("rec_wr", 16);

        // ip_done on the final watchdog cycle wins over the timeout
        kick(8);
        wait_idle("co_idle", 400);
        chk("co_busy_fall", 64'(cyc - t0), 64'd193);
        chk("co_err", 64'(err), 64'd0);
        chk("co_done", 64'(done_cnt), 64'd1);
        check_writes("co_wr", 16);

        // abort during WAIT of element 5
        kick(5);
        go_to(49);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abw_busy", 64'(busy), 64'd0);
        chk("abw_ip_rst", 64'(ip_rst), 64'd0);
        chk("abw_ip_start", 64'(ip_start), 64'd0);
        repeat (4) @(negedge clk);
        chk("abw_done", 64'(done_cnt), 64'd0);
        chk("abw_err", 64'(err), 64'd0);
        check_writes("abw_wr", 5);

        // abort coinciding with WRITE of element 5
        kick(5);
        go_to(53);
        abort = 1'b1;
        @(negedge clk);
        chk("abx_state", 64'(state_dbg), 64'd4);
        chk("abx_res_we", 64'(res_we), 64'd0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abx_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("abx_done", 64'(done_cnt), 64'd0);
        check_writes("abx_wr", 5);

        // asynchronous reset during ENG_RST of element 3
        kick(5);
        go_to(27);
        rst = 1'b0;
        #1;
        chk("mr_ip_rst", 64'(ip_rst), 64'd0);
        chk("mr_ip_start", 64'(ip_start), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_res_we", 64'(res_we), 64'd0);
        chk("mr_res_data", 64'(res_data), 64'd0);
        chk("mr_state", 64'(state_dbg), 64'd0);
        check_writes("mr_pre", 3);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mr_no_write", 64'(wr_q.size()), 64'd3);
        kick(5);
        wait_idle("mr_idle", 400);
        chk("mr_done", 64'(done_cnt), 64'd1);
        check_writes("mr_wr", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
